layer1_gain_array: RTL and testbench

Parametrised multi-column successor to the single-column L1 apical gain block. Computes, for N_CH cortical columns, gain = 1.0 + Σ w_i·in_i over N_IN modulatory inputs (matrix thalamic, adjacent feedback, distant feedback, …). A single time-multiplexed MAC does the arithmetic, followed by per-column clamping. It sits between the thalamic/feedback routing and the L2/3–L5 apical gain consumers. Results are committed coherently, all columns at once, with a valid pulse.

---
 rtl/layer1_gain_array.sv | 212 +++++++++++++++++++++
 tb/tb_layer1_gain_array.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer1_gain_array.sv
`default_nettype none
// ============================================================================
// Module      : layer1_gain_array
// Description : Layer-1 apical gain for N_CH cortical columns.
//               gain = 1.0 + sum(w_i * in_i) over N_IN modulatory inputs,
//               computed on one time-multiplexed MAC, clamped per column to
//               [GAIN_MIN, GAIN_MAX] and committed to all columns at once.
//               Optional macro LAYER1_GAIN_SLEW_EN additionally limits each
//               column's change per update to +/- SLEW_STEP.
// Revision    : 1.0 - initial release
// ============================================================================
module layer1_gain_array #(
    parameter int WIDTH     = 18,
    parameter int FRAC      = 14,
    parameter int N_CH      = 4,
    parameter int N_IN      = 3,
    parameter int GAIN_MIN  = 8192,
    parameter int GAIN_MAX  = 24576,
    parameter int SLEW_STEP = 1638
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clk_en,
    input  logic                        start,
    input  logic [N_CH*N_IN*WIDTH-1:0]  in_flat,
    input  logic [N_IN*WIDTH-1:0]       weight_flat,
    output logic [N_CH*WIDTH-1:0]       apical_gain_flat,
    output logic [N_CH-1:0]             sat_hi,
    output logic [N_CH-1:0]             sat_lo,
    output logic                        gain_valid,
    output logic                        busy,
    output logic                        start_dropped
);

    localparam int ACC_W = 2*WIDTH + $clog2(N_IN) + 1;
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int IN_W  = (N_IN > 1) ? $clog2(N_IN) : 1;

    localparam logic signed [ACC_W-1:0] c_one    = ACC_W'(1 << FRAC);
    localparam logic signed [ACC_W-1:0] c_gmax   = ACC_W'(GAIN_MAX);
    localparam logic signed [ACC_W-1:0] c_gmin   = ACC_W'(GAIN_MIN);
    localparam logic signed [WIDTH-1:0] c_one_w  = WIDTH'(1 << FRAC);
    localparam logic signed [WIDTH-1:0] c_gmax_w = WIDTH'(GAIN_MAX);
    localparam logic signed [WIDTH-1:0] c_gmin_w = WIDTH'(GAIN_MIN);
    localparam logic signed [WIDTH-1:0] c_slew_w = WIDTH'(SLEW_STEP);
    localparam logic [CH_W-1:0]         c_ch_last = CH_W'(N_CH - 1);
    localparam logic [IN_W-1:0]         c_in_last = IN_W'(N_IN - 1);

`ifdef LAYER1_GAIN_SLEW_EN
    localparam bit c_slew_en = 1'b1;
`else
    localparam bit c_slew_en = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MAC    = 2'd1,
        S_WRITE  = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [N_CH*N_IN*WIDTH-1:0] r_in_snap;
    logic [N_IN*WIDTH-1:0]      r_w_snap;
    logic signed [ACC_W-1:0]    r_acc;
    logic [CH_W-1:0]            r_ch;
    logic [IN_W-1:0]            r_i;
    logic [N_CH*WIDTH-1:0]      r_shadow;
    logic [N_CH-1:0]            r_sh_hi;
    logic [N_CH-1:0]            r_sh_lo;

    logic signed [WIDTH-1:0]    w_in_sel;
    logic signed [WIDTH-1:0]    w_w_sel;
    logic signed [WIDTH-1:0]    w_prev;
    logic signed [2*WIDTH-1:0]  w_prod;
    logic signed [ACC_W-1:0]    w_t;
    logic                       w_hi;
    logic                       w_lo;
    logic signed [WIDTH-1:0]    w_clamped;
    logic signed [WIDTH-1:0]    w_new;

    // State register; frozen whenever clk_en is low
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else if (clk_en) begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: IDLE -> (MAC x N_IN -> WRITE) x N_CH -> COMMIT
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_next = S_MAC;
            S_MAC:    if (r_i == c_in_last) w_state_next = S_WRITE;
            S_WRITE:  w_state_next = (r_ch == c_ch_last) ? S_COMMIT : S_MAC;
            S_COMMIT: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Operand and previous-gain selection for the current column/input
    always_comb begin
        w_in_sel = '0;
        w_w_sel  = '0;
        w_prev   = '0;
        for (int c = 0; c < N_CH; c++) begin
            for (int i = 0; i < N_IN; i++) begin
                if (r_ch == CH_W'(c) && r_i == IN_W'(i))
                    w_in_sel = r_in_snap[(c*N_IN+i)*WIDTH +: WIDTH];
            end
            if (r_ch == CH_W'(c))
                w_prev = apical_gain_flat[c*WIDTH +: WIDTH];
        end
        for (int i = 0; i < N_IN; i++) begin
            if (r_i == IN_W'(i))
                w_w_sel = r_w_snap[i*WIDTH +: WIDTH];
        end
    end

    // Full-width product, then floor-shift, bias by ONE, clamp without wrap
    always_comb begin
        w_prod = (2*WIDTH)'(w_in_sel) * (2*WIDTH)'(w_w_sel);
        w_t    = (r_acc >>> FRAC) + c_one;
        w_hi   = (w_t > c_gmax);
        w_lo   = (w_t < c_gmin);
        if (w_hi)
            w_clamped = c_gmax_w;
        else if (w_lo)
            w_clamped = c_gmin_w;
        else
            w_clamped = w_t[WIDTH-1:0];
        w_new = w_clamped;
        if (c_slew_en) begin
            if (w_clamped > w_prev + c_slew_w)
                w_new = w_prev + c_slew_w;
            else if (w_clamped < w_prev - c_slew_w)
                w_new = w_prev - c_slew_w;
        end
    end

    // Datapath: snapshot, accumulate, per-column write, coherent commit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_in_snap        <= '0;
            r_w_snap         <= '0;
            r_acc            <= '0;
            r_ch             <= '0;
            r_i              <= '0;
            r_shadow         <= {N_CH{c_one_w}};
            r_sh_hi          <= '0;
            r_sh_lo          <= '0;
            apical_gain_flat <= {N_CH{c_one_w}};
            sat_hi           <= '0;
            sat_lo           <= '0;
            busy             <= 1'b0;
        end else if (clk_en) begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_in_snap <= in_flat;
                        r_w_snap  <= weight_flat;
                        r_acc     <= '0;
                        r_ch      <= '0;
                        r_i       <= '0;
                        busy      <= 1'b1;
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + ACC_W'(w_prod);
                    r_i   <= r_i + 1'b1;
                end
                S_WRITE: begin
                    for (int c = 0; c < N_CH; c++) begin
                        if (r_ch == CH_W'(c)) begin
                            r_shadow[c*WIDTH +: WIDTH] <= w_new;
                            r_sh_hi[c]                 <= w_hi;
                            r_sh_lo[c]                 <= w_lo;
                        end
                    end
                    r_acc <= '0;
                    r_i   <= '0;
                    if (r_ch != c_ch_last)
                        r_ch <= r_ch + 1'b1;
                end
                S_COMMIT: begin
                    apical_gain_flat <= r_shadow;
                    sat_hi           <= r_sh_hi;
                    sat_lo           <= r_sh_lo;
                    busy             <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Single-clk status pulses, generated on every clk regardless of clk_en
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gain_valid    <= 1'b0;
            start_dropped <= 1'b0;
        end else begin
            gain_valid    <= clk_en && (r_state == S_COMMIT);
            start_dropped <= clk_en && start && busy;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_layer1_gain_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_layer1_gain_array
// Description : Scoreboard bench for layer1_gain_array. Stimulus pushes the
//               hand-computed expected column set; a monitor pops and compares
//               on every gain_valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_layer1_gain_array;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clk_en;
    logic         start;
    logic [215:0] in_flat;
    logic [53:0]  weight_flat;
    logic [71:0]  apical_gain_flat;
    logic [3:0]   sat_hi;
    logic [3:0]   sat_lo;
    logic         gain_valid;
    logic         busy;
    logic         start_dropped;

    typedef struct packed {
        logic [3:0][17:0] g;
        logic [3:0]       hi;
        logic [3:0]       lo;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    bit   toggle_en = 1'b0;

    always #5 clk = ~clk;

    layer1_gain_array dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .clk_en           (clk_en),
        .start            (start),
        .in_flat          (in_flat),
        .weight_flat      (weight_flat),
        .apical_gain_flat (apical_gain_flat),
        .sat_hi           (sat_hi),
        .sat_lo           (sat_lo),
        .gain_valid       (gain_valid),
        .busy             (busy),
        .start_dropped    (start_dropped)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: every gain_valid pulse must match the oldest expected entry
    always @(negedge clk) begin
        if (gain_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_gain_valid", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                for (int c = 0; c < 4; c++)
                    chk($sformatf("gain_col%0d", c),
                        int'($signed(apical_gain_flat[c*18 +: 18])),
                        int'($signed(mon_e.g[c])));
                chk("sat_hi", int'(sat_hi), int'(mon_e.hi));
                chk("sat_lo", int'(sat_lo), int'(mon_e.lo));
            end
        end
    end

    task automatic set_one(input int c, input int i, input int v);
        in_flat[(c*3+i)*18 +: 18] = 18'(v);
    endtask

    task automatic set_all(input int v);
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 3; i++)
                set_one(c, i, v);
    endtask

    task automatic set_w(input int w0, input int w1, input int w2);
        weight_flat = {18'(w2), 18'(w1), 18'(w0)};
    endtask

    task automatic push_exp(input int g0, input int g1, input int g2, input int g3,
                            input logic [3:0] hi, input logic [3:0] lo);
        exp_t e;
        e.g[0] = 18'(g0);
        e.g[1] = 18'(g1);
        e.g[2] = 18'(g2);
        e.g[3] = 18'(g3);
        e.hi   = hi;
        e.lo   = lo;
        sb.push_back(e);
    endtask

    // Scenario 2 input pattern
    task automatic set_pattern_a();
        set_all(0);
        set_one(0, 0, 16384);
        set_one(1, 1, 16384);
        set_one(2, 2, 16384);
        for (int i = 0; i < 3; i++) set_one(3, i, -16384);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        clk_en = 1'b0;
        start  = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        clk_en = 1'b1;
    endtask

    // Issue one start and count enabled edges until gain_valid appears
    task automatic run_update(input string name);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        @(negedge clk);
        clk_en = 1'b1;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({name, "_busy"}, int'(busy), 1);
        for (int cyc = 0; cyc < 200 && !got; cyc++) begin
            if (toggle_en) clk_en = ~clk_en;
            else           clk_en = 1'b1;
            @(posedge clk);
            if (clk_en) n++;
            #1;
            if (gain_valid) got = 1'b1;
            @(negedge clk);
        end
        chk({name, "_valid_seen"}, int'(got), 1);
        chk({name, "_latency"}, n, 17);
        clk_en = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        rst_n  = 1'b0;
        clk_en = 1'b0;
        start  = 1'b0;
        set_all(0);
        set_w(2458, 4915, 3277);
        do_reset();
        @(negedge clk);
        for (int c = 0; c < 4; c++)
            chk($sformatf("reset_gain%0d", c), int'(apical_gain_flat[c*18 +: 18]), 16384);
        chk("reset_sat_hi", int'(sat_hi), 0);
        chk("reset_sat_lo", int'(sat_lo), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_valid", int'(gain_valid), 0);
        chk("reset_dropped", int'(start_dropped), 0);

`ifdef LAYER1_GAIN_SLEW_EN
        set_all(16384);
        push_exp(18022, 18022, 18022, 18022, 4'b1111, 4'b0000);
        run_update("slew1");
        push_exp(19660, 19660, 19660, 19660, 4'b1111, 4'b0000);
        run_update("slew2");
        push_exp(21298, 21298, 21298, 21298, 4'b1111, 4'b0000);
        run_update("slew3");
        push_exp(22936, 22936, 22936, 22936, 4'b1111, 4'b0000);
        run_update("slew4");
        push_exp(24574, 24574, 24574, 24574, 4'b1111, 4'b0000);
        run_update("slew5");
        push_exp(24576, 24576, 24576, 24576, 4'b1111, 4'b0000);
        run_update("slew6");
`else
        // All-zero inputs: unity gain
        push_exp(16384, 16384, 16384, 16384, 4'b0000, 4'b0000);
        run_update("zero");

        // One input per column, column 3 driven negative into the low clamp
        set_pattern_a();
        push_exp(18842, 21299, 19661, 8192, 4'b0000, 4'b1000);
        run_update("pattern_a");

        // Saturation high, including a magnitude that would wrap a narrow sum
        set_all(16384);
        push_exp(24576, 24576, 24576, 24576, 4'b1111, 4'b0000);
        run_update("sat_16384");
        set_all(32768);
        push_exp(24576, 24576, 24576, 24576, 4'b1111, 4'b0000);
        run_update("sat_32768");

        // Clamp edges with unity weight: exactly at a limit is not saturated
        set_all(0);
        set_w(16384, 0, 0);
        set_one(0, 0, 8192);
        set_one(1, 0, 8193);
        set_one(2, 0, -8192);
        set_one(3, 0, -8193);
        push_exp(24576, 24576, 8192, 8192, 4'b0010, 4'b1000);
        run_update("clamp_edges");

        // Arithmetic shift floors negative sums
        set_all(0);
        set_w(2458, 4915, 3277);
        set_one(0, 0, -1);
        push_exp(16383, 16384, 16384, 16384, 4'b0000, 4'b0000);
        run_update("floor");

        // Start while busy is dropped; result comes from the first snapshot
        set_pattern_a();
        push_exp(18842, 21299, 19661, 8192, 4'b0000, 4'b1000);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        set_all(16384);
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("start_dropped_pulse", int'(start_dropped), 1);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("start_dropped_clear", int'(start_dropped), 0);
        got = 1'b0;
        for (int cyc = 0; cyc < 40 && !got; cyc++) begin
            @(posedge clk);
            #1;
            if (gain_valid) got = 1'b1;
        end
        chk("dropped_valid_seen", int'(got), 1);
        repeat (25) @(negedge clk);

        // Reset in the middle of a computation discards it
        set_all(16384);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        do_reset();
        #1;
        for (int c = 0; c < 4; c++)
            chk($sformatf("midreset_gain%0d", c), int'(apical_gain_flat[c*18 +: 18]), 16384);
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_sat_lo", int'(sat_lo), 0);
        repeat (30) @(negedge clk);
        chk("midreset_busy_later", int'(busy), 0);

        // Alternating clk_en stretches the update but not the result
        set_pattern_a();
        push_exp(18842, 21299, 19661, 8192, 4'b0000, 4'b1000);
        toggle_en = 1'b1;
        run_update("clk_en_toggle");
        toggle_en = 1'b0;
`endif

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
